// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: round-robin sharing of the memory_io bus between NUM_REQ
// requesters. One command is accepted per cycle, the bus is driven from
// registers, and read data is steered back to the issuer by a tag pipeline
// whose depth matches the fixed bus read latency.
module io_bus_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int READ_LATENCY = 2
) (
    input  logic                    main_clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0]      req_write,
    input  logic [32*NUM_REQ-1:0]   req_address,
    input  logic [16*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]      ack,
    output logic [15:0]             rdata,
    output logic [NUM_REQ-1:0]      rvalid,
    input  logic                    bus_hold,
    output logic [31:0]             address_io,
    output logic [15:0]             data_out_io,
    output logic [1:0]              control_io,
    input  logic [15:0]             data_in_io
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);
    localparam logic [IDW:0]   NUM_REQ_W = (IDW+1)'(NUM_REQ);

    localparam logic [1:0] CTRL_IDLE  = 2'b00;
    localparam logic [1:0] CTRL_READ  = 2'b01;
    localparam logic [1:0] CTRL_WRITE = 2'b10;

    // Arbitration state and combinational grant
    logic [IDW-1:0]     last_grant_r;
    logic [IDW-1:0]     winner_s;
    logic               found_s;
    logic               accept_s;
    logic [IDW:0]       sum_s;
    logic [NUM_REQ-1:0] ack_s;

    // Winner payload
    logic [31:0]        win_addr_s;
    logic [15:0]        win_wdata_s;
    logic               win_write_s;

    // Requester id of the command currently on the bus
    logic [IDW-1:0]     bus_id_r;

    // Read tag pipeline: one entry per bus cycle, valid only for reads
    logic [READ_LATENCY-1:0]          tag_valid_r;
    logic [READ_LATENCY-1:0][IDW-1:0] tag_id_r;
    logic [NUM_REQ-1:0]               rvalid_nxt_s;

    // Round-robin search starting one past the last winner, masked by bus_hold
    always_comb begin
        winner_s = '0;
        found_s  = 1'b0;
        sum_s    = '0;
        ack_s    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            sum_s = {1'b0, last_grant_r} + (IDW+1)'(i);
            if (sum_s >= NUM_REQ_W) begin
                sum_s = sum_s - NUM_REQ_W;
            end else begin
                sum_s = sum_s;
            end
            if (!found_s && req[sum_s[IDW-1:0]]) begin
                found_s  = 1'b1;
                winner_s = sum_s[IDW-1:0];
            end else begin
                found_s  = found_s;
            end
        end
        accept_s = found_s && !bus_hold;
        if (accept_s) begin
            ack_s[winner_s] = 1'b1;
        end else begin
            ack_s = '0;
        end
    end

    assign ack = ack_s;

    // Select the winning requester's command fields
    always_comb begin
        win_addr_s  = req_address[{winner_s, 5'd0} +: 32];
        win_wdata_s = req_wdata[{winner_s, 4'd0} +: 16];
        win_write_s = req_write[winner_s];
    end

    // Bus command registers and round-robin pointer update on acceptance
    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= LAST_ID;
            bus_id_r     <= '0;
            address_io   <= 32'h0000_0000;
            data_out_io  <= 16'h0000;
            control_io   <= CTRL_IDLE;
        end else if (accept_s) begin
            last_grant_r <= winner_s;
            bus_id_r     <= winner_s;
            address_io   <= win_addr_s;
            data_out_io  <= win_wdata_s;
            control_io   <= win_write_s ? CTRL_WRITE : CTRL_READ;
        end else begin
            control_io   <= CTRL_IDLE;
        end
    end

    // Tag pipeline: every bus cycle enters, aligned so the tail meets data_in_io
    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid_r <= '0;
            tag_id_r    <= '0;
        end else begin
            tag_valid_r[0] <= (control_io == CTRL_READ);
            tag_id_r[0]    <= bus_id_r;
            for (int k = 1; k < READ_LATENCY; k++) begin
                tag_valid_r[k] <= tag_valid_r[k-1];
                tag_id_r[k]    <= tag_id_r[k-1];
            end
        end
    end

    // One-hot return strobe for the entry leaving the tag pipeline
    always_comb begin
        rvalid_nxt_s = '0;
        if (tag_valid_r[READ_LATENCY-1]) begin
            rvalid_nxt_s[tag_id_r[READ_LATENCY-1]] = 1'b1;
        end else begin
            rvalid_nxt_s = '0;
        end
    end

    // Read return registers; rdata keeps its last value between returns
    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata  <= 16'h0000;
            rvalid <= '0;
        end else begin
            rvalid <= rvalid_nxt_s;
            if (tag_valid_r[READ_LATENCY-1]) begin
                rdata <= data_in_io;
            end
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter (NUM_REQ=2, READ_LATENCY=2).
// A behavioural memory answers bus reads after READ_LATENCY cycles; expected
// read returns are queued when a read is accepted and checked by a monitor.
module tb_io_bus_arbiter;

    localparam int N = 2;
    localparam int L = 2;

    logic            main_clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N-1:0]    req_write;
    logic [32*N-1:0] req_address;
    logic [16*N-1:0] req_wdata;
    logic [N-1:0]    ack;
    logic [15:0]     rdata;
    logic [N-1:0]    rvalid;
    logic            bus_hold;
    logic [31:0]     address_io;
    logic [15:0]     data_out_io;
    logic [1:0]      control_io;
    logic [15:0]     data_in_io;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    typedef struct { int id; logic [15:0] data; int due; } exp_t;
    typedef struct { int due; logic [15:0] data; } mem_t;
    exp_t exp_q[$];
    mem_t mem_q[$];

    io_bus_arbiter #(.NUM_REQ(N), .READ_LATENCY(L)) dut (
        .main_clk(main_clk), .rst_n(rst_n), .req(req), .req_write(req_write),
        .req_address(req_address), .req_wdata(req_wdata), .ack(ack),
        .rdata(rdata), .rvalid(rvalid), .bus_hold(bus_hold),
        .address_io(address_io), .data_out_io(data_out_io),
        .control_io(control_io), .data_in_io(data_in_io)
    );

    always #5 main_clk = ~main_clk;

    always @(posedge main_clk) cyc <= cyc + 1;

    function automatic logic [15:0] mem_func(input logic [31:0] a);
        case (a)
            32'h0000_1000: mem_func = 16'hBEEF;
            32'h0000_0010: mem_func = 16'h000A;
            32'h0000_0020: mem_func = 16'h000B;
            default:       mem_func = a[15:0] ^ 16'h5A5A;
        endcase
    endfunction

    // Memory model: read seen on the bus in cycle c -> data valid in cycle c+L
    initial begin
        mem_t m;
        data_in_io = 16'hDEAD;
        forever begin
            @(posedge main_clk); #1;
            if (control_io == 2'b01) begin
                m.due  = cyc + L;
                m.data = mem_func(address_io);
                mem_q.push_back(m);
            end
            if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
                data_in_io = mem_q[0].data;
                void'(mem_q.pop_front());
            end else begin
                data_in_io = 16'hDEAD;
            end
        end
    end

    // Read-return monitor: each cycle rvalid must match the scoreboard
    initial begin
        logic [N-1:0] exp_rv;
        forever begin
            @(posedge main_clk); #1;
            tests_run++;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                exp_rv = '0;
                exp_rv[exp_q[0].id] = 1'b1;
                if (rvalid !== exp_rv || rdata !== exp_q[0].data) begin
                    tests_failed++;
                    $display("FAIL read_return cyc=%0d: rvalid=%b rdata=%h, want rvalid=%b rdata=%h",
                             cyc, rvalid, rdata, exp_rv, exp_q[0].data);
                end
                void'(exp_q.pop_front());
            end else if (rvalid !== '0) begin
                tests_failed++;
                $display("FAIL spurious_rvalid cyc=%0d: rvalid=%b want 0", cyc, rvalid);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step;
        @(posedge main_clk); #1;
    endtask

    task automatic set_cmd(input int id, input logic w, input logic [31:0] a, input logic [15:0] d);
        req_write[id]          = w;
        req_address[32*id +: 32] = a;
        req_wdata[16*id +: 16]   = d;
    endtask

    task automatic push_read(input int id, input logic [15:0] d);
        exp_t e;
        e.id = id; e.data = d; e.due = cyc + 2 + L;
        exp_q.push_back(e);
    endtask

    task automatic do_reset;
        @(negedge main_clk);
        rst_n = 1'b0;
        exp_q.delete();
        step; step;
        @(negedge main_clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step; step;
        tests_run++;
        if (control_io !== 2'b00 || address_io !== 32'h0 || data_out_io !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_bus: ctrl=%b addr=%h data=%h want 00/0/0", control_io, address_io, data_out_io);
        end
        tests_run++;
        if (rdata !== 16'h0 || rvalid !== 2'b00 || ack !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_ret: rdata=%h rvalid=%b ack=%b want 0", rdata, rvalid, ack);
        end
        @(negedge main_clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_read;
        step;
        set_cmd(0, 1'b0, 32'h0000_1000, 16'h0000);
        req = 2'b01; #1;
        tests_run++;
        if (ack !== 2'b01) begin tests_failed++; $display("FAIL single_read.ack: got %b want 01", ack); end
        push_read(0, 16'hBEEF);
        step;
        req = 2'b00;
        tests_run++;
        if (control_io !== 2'b01 || address_io !== 32'h0000_1000) begin
            tests_failed++;
            $display("FAIL single_read.bus: ctrl=%b addr=%h want 01/00001000", control_io, address_io);
        end
        repeat (4) step;
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_ack;
        logic [31:0] pa;
        logic [15:0] pd;
        do_reset;
        for (int k = 0; k < 4; k++) begin
            step;
            set_cmd(0, 1'b1, 32'h0000_0100, 16'h1111);
            set_cmd(1, 1'b1, 32'h0000_0200, 16'h2222);
            req = 2'b11;
            if (k > 0) begin
                pa = ((k-1) % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200;
                pd = ((k-1) % 2 == 0) ? 16'h1111 : 16'h2222;
                tests_run++;
                if (control_io !== 2'b10 || address_io !== pa || data_out_io !== pd) begin
                    tests_failed++;
                    $display("FAIL round_robin.bus k=%0d: ctrl=%b addr=%h data=%h want 10/%h/%h",
                             k, control_io, address_io, data_out_io, pa, pd);
                end
            end
            #1;
            exp_ack = (k % 2 == 0) ? 2'b01 : 2'b10;
            tests_run++;
            if (ack !== exp_ack) begin
                tests_failed++;
                $display("FAIL round_robin.ack k=%0d: got %b want %b", k, ack, exp_ack);
            end
        end
        step;
        req = 2'b00;
        tests_run++;
        if (control_io !== 2'b10 || address_io !== 32'h0000_0200 || data_out_io !== 16'h2222) begin
            tests_failed++;
            $display("FAIL round_robin.last: ctrl=%b addr=%h data=%h want 10/00000200/2222",
                     control_io, address_io, data_out_io);
        end
    endtask

    task automatic test_interleaved;
        step;
        set_cmd(0, 1'b0, 32'h0000_0010, 16'h0000);
        req = 2'b01; #1;
        tests_run++;
        if (ack !== 2'b01) begin tests_failed++; $display("FAIL interleaved.ack0: got %b want 01", ack); end
        push_read(0, 16'h000A);
        step;
        set_cmd(1, 1'b0, 32'h0000_0020, 16'h0000);
        req = 2'b10;
        tests_run++;
        if (control_io !== 2'b01 || address_io !== 32'h0000_0010) begin
            tests_failed++;
            $display("FAIL interleaved.bus0: ctrl=%b addr=%h want 01/00000010", control_io, address_io);
        end
        #1;
        tests_run++;
        if (ack !== 2'b10) begin tests_failed++; $display("FAIL interleaved.ack1: got %b want 10", ack); end
        push_read(1, 16'h000B);
        step;
        req = 2'b00;
        tests_run++;
        if (control_io !== 2'b01 || address_io !== 32'h0000_0020) begin
            tests_failed++;
            $display("FAIL interleaved.bus1: ctrl=%b addr=%h want 01/00000020", control_io, address_io);
        end
        repeat (5) step;
    endtask

    task automatic test_back_pressure;
        step;
        set_cmd(0, 1'b0, 32'h0000_0300, 16'h0000);
        req = 2'b01; #1;
        tests_run++;
        if (ack !== 2'b01) begin tests_failed++; $display("FAIL back_pressure.pre_ack: got %b want 01", ack); end
        push_read(0, mem_func(32'h0000_0300));
        step;
        set_cmd(1, 1'b1, 32'h0000_0400, 16'hCAFE);
        req = 2'b10;
        bus_hold = 1'b1;
        tests_run++;
        if (control_io !== 2'b01) begin tests_failed++; $display("FAIL back_pressure.pre_bus: ctrl=%b want 01", control_io); end
        for (int k = 0; k < 3; k++) begin
            #1;
            tests_run++;
            if (ack !== 2'b00) begin tests_failed++; $display("FAIL back_pressure.ack k=%0d: got %b want 00", k, ack); end
            step;
            if (k == 2) bus_hold = 1'b0;
            tests_run++;
            if (control_io !== 2'b00) begin tests_failed++; $display("FAIL back_pressure.idle k=%0d: ctrl=%b want 00", k, control_io); end
        end
        #1;
        tests_run++;
        if (ack !== 2'b10) begin tests_failed++; $display("FAIL back_pressure.release_ack: got %b want 10", ack); end
        step;
        req = 2'b00;
        tests_run++;
        if (control_io !== 2'b10 || address_io !== 32'h0000_0400 || data_out_io !== 16'hCAFE) begin
            tests_failed++;
            $display("FAIL back_pressure.bus: ctrl=%b addr=%h data=%h want 10/00000400/cafe",
                     control_io, address_io, data_out_io);
        end
        repeat (3) step;
    endtask

    task automatic test_back_to_back;
        logic [31:0] a;
        for (int k = 0; k < 5; k++) begin
            step;
            a = 32'h0000_0600 + 32'(2*k);
            set_cmd(1, 1'b0, a, 16'h0000);
            req = 2'b10;
            if (k > 0) begin
                tests_run++;
                if (control_io !== 2'b01 || address_io !== a - 32'd2) begin
                    tests_failed++;
                    $display("FAIL back_to_back.bus k=%0d: ctrl=%b addr=%h want 01/%h", k, control_io, address_io, a - 32'd2);
                end
            end
            #1;
            tests_run++;
            if (ack !== 2'b10) begin tests_failed++; $display("FAIL back_to_back.ack k=%0d: got %b want 10", k, ack); end
            push_read(1, mem_func(a));
        end
        step;
        req = 2'b00;
        tests_run++;
        if (control_io !== 2'b01 || address_io !== 32'h0000_0608) begin
            tests_failed++;
            $display("FAIL back_to_back.last: ctrl=%b addr=%h want 01/00000608", control_io, address_io);
        end
        repeat (5) step;
    endtask

    task automatic test_reset_mid_read;
        step;
        set_cmd(0, 1'b0, 32'h0000_0500, 16'h0000);
        req = 2'b01; #1;
        tests_run++;
        if (ack !== 2'b01) begin tests_failed++; $display("FAIL reset_mid.ack: got %b want 01", ack); end
        step;
        req = 2'b00;
        tests_run++;
        if (control_io !== 2'b01) begin tests_failed++; $display("FAIL reset_mid.bus: ctrl=%b want 01", control_io); end
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        tests_run++;
        if (control_io !== 2'b00 || address_io !== 32'h0 || data_out_io !== 16'h0 ||
            rdata !== 16'h0 || rvalid !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_mid.outputs: ctrl=%b addr=%h data=%h rdata=%h rvalid=%b want all 0",
                     control_io, address_io, data_out_io, rdata, rvalid);
        end
        step; step;
        @(negedge main_clk);
        rst_n = 1'b1;
        step;
        set_cmd(0, 1'b1, 32'h0000_0700, 16'h7777);
        set_cmd(1, 1'b1, 32'h0000_0800, 16'h8888);
        req = 2'b11;
        tests_run++;
        if (control_io !== 2'b00) begin tests_failed++; $display("FAIL reset_mid.idle: ctrl=%b want 00", control_io); end
        #1;
        tests_run++;
        if (ack !== 2'b01) begin tests_failed++; $display("FAIL reset_mid.first_grant: got %b want 01", ack); end
        step;
        req = 2'b00;
        tests_run++;
        if (control_io !== 2'b10 || address_io !== 32'h0000_0700 || data_out_io !== 16'h7777) begin
            tests_failed++;
            $display("FAIL reset_mid.after: ctrl=%b addr=%h data=%h want 10/00000700/7777",
                     control_io, address_io, data_out_io);
        end
        repeat (4) step;
    endtask

    task automatic test_idle_hold;
        step;
        set_cmd(0, 1'b1, 32'h0000_1234, 16'h5678);
        req = 2'b01; #1;
        tests_run++;
        if (ack !== 2'b01) begin tests_failed++; $display("FAIL idle_hold.ack: got %b want 01", ack); end
        step;
        req = 2'b00;
        set_cmd(0, 1'b0, 32'hFFFF_0000, 16'h0000);
        tests_run++;
        if (control_io !== 2'b10 || address_io !== 32'h0000_1234 || data_out_io !== 16'h5678) begin
            tests_failed++;
            $display("FAIL idle_hold.write: ctrl=%b addr=%h data=%h want 10/00001234/5678",
                     control_io, address_io, data_out_io);
        end
        for (int k = 0; k < 3; k++) begin
            step;
            tests_run++;
            if (control_io !== 2'b00 || address_io !== 32'h0000_1234 || data_out_io !== 16'h5678) begin
                tests_failed++;
                $display("FAIL idle_hold.idle k=%0d: ctrl=%b addr=%h data=%h want 00/00001234/5678",
                         k, control_io, address_io, data_out_io);
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        req         = '0;
        req_write   = '0;
        req_address = '0;
        req_wdata   = '0;
        bus_hold    = 1'b0;
        test_reset;
        test_single_read;
        test_round_robin;
        test_interleaved;
        test_back_pressure;
        test_back_to_back;
        test_reset_mid_read;
        test_idle_hold;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: %0d read returns outstanding, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
